// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: execute-stage request and HI/LO result bundle for hilo_muldiv_unit
// Signals: valid_i, alucontrol_i, src_a_i, src_b_i, flush_i (pipeline -> unit);
//          stall_o, busy_o, hi_o, lo_o (unit -> pipeline).
// Modports: master = pipeline side, slave = unit side.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [4:0]       alucontrol_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             flush_i;
    logic             stall_o;
    logic             busy_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    modport master(
        output valid_i, alucontrol_i, src_a_i, src_b_i, flush_i,
        input  stall_o, busy_o, hi_o, lo_o
    );
    modport slave(
        input  valid_i, alucontrol_i, src_a_i, src_b_i, flush_i,
        output stall_o, busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: execute-stage HI/LO unit running MULT/MULTU/DIV/DIVU/MTHI/MTLO
// Ports: clk, rst (synchronous, active-high); bus (hilo_muldiv_if.slave) carrying
//   valid_i, alucontrol_i, src_a_i, src_b_i, flush_i in and stall_o, busy_o, hi_o, lo_o out.
// Division is a WIDTH-step restoring divider that stalls the pipeline while it runs.
// Define MULT_ITER_EN to run MULT/MULTU as a WIDTH-step shift-add with the same stall
// behaviour as division; otherwise they use a single-cycle combinational multiply.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);
    localparam logic [4:0] MULT_C  = 5'b11000;
    localparam logic [4:0] MULTU_C = 5'b11001;
    localparam logic [4:0] DIV_C   = 5'b11010;
    localparam logic [4:0] DIVU_C  = 5'b11011;
    localparam logic [4:0] MTHI_C  = 5'b11100;
    localparam logic [4:0] MTLO_C  = 5'b11101;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
`ifdef MULT_ITER_EN
        MUL_RUN,
`endif
        DIV_RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi, lo, acc, sh, opnd, abs_a, abs_b, d_acc, d_sh, run_acc, run_sh;
    logic [WIDTH:0]   rem_sh;
    logic [CW-1:0]    cnt;
    logic [4:0]       code;
    logic             sa, sb, done, busy, is_div, is_mul, sgn, a_neg, b_neg, start, long_op, ge;
`ifdef MULT_ITER_EN
    logic [WIDTH:0]   sum;
`else
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
`endif

    assign code = bus.alucontrol_i;
    assign bus.hi_o = hi;
    assign bus.lo_o = lo;
    assign bus.busy_o = busy;
    // In IDLE only a starting long operation stalls; while running, flush releases the stall at once.
    assign bus.stall_o = (state == IDLE) ? (start && long_op) : !bus.flush_i;

    always_comb begin
        is_div  = code == DIV_C || code == DIVU_C;
        is_mul  = code == MULT_C || code == MULTU_C;
        sgn     = code == DIV_C || code == MULT_C;
        a_neg   = sgn & bus.src_a_i[WIDTH-1];
        b_neg   = sgn & bus.src_b_i[WIDTH-1];
        abs_a   = a_neg ? -bus.src_a_i : bus.src_a_i;
        abs_b   = b_neg ? -bus.src_b_i : bus.src_b_i;
        // done blocks a restart on the instruction still held in the cycle after completion
        start   = state == IDLE && bus.valid_i && !bus.flush_i && !done;
`ifdef MULT_ITER_EN
        long_op = is_div | is_mul;
`else
        long_op = is_div;
`endif
        // restoring step: shift the next dividend bit into the partial remainder
        rem_sh  = {acc, sh[WIDTH-1]};
        ge      = rem_sh >= {1'b0, opnd};
        d_acc   = ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
        d_sh    = {sh[WIDTH-2:0], ge};
`ifdef MULT_ITER_EN
        // shift-add step: {acc, sh} holds the partial product with the multiplier in sh
        sum     = {1'b0, acc} + {1'b0, sh[0] ? opnd : '0};
        run_acc = (state == MUL_RUN) ? sum[WIDTH:1] : d_acc;
        run_sh  = (state == MUL_RUN) ? {sum[0], sh[WIDTH-1:1]} : d_sh;
`else
        prod_s  = $signed(bus.src_a_i) * $signed(bus.src_b_i);
        prod_u  = {{WIDTH{1'b0}}, bus.src_a_i} * {{WIDTH{1'b0}}, bus.src_b_i};
        run_acc = d_acc;
        run_sh  = d_sh;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            sh    <= '0;
            opnd  <= '0;
            cnt   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && is_div && bus.src_b_i == '0) begin
                    lo   <= '1;
                    hi   <= bus.src_a_i;
                    done <= 1'b1;
                end else if (start && long_op) begin
                    acc  <= '0;
                    sh   <= abs_a;
                    opnd <= abs_b;
                    sa   <= a_neg;
                    sb   <= b_neg;
                    cnt  <= '0;
                    busy <= 1'b1;
`ifdef MULT_ITER_EN
                    state <= is_div ? DIV_RUN : MUL_RUN;
`else
                    state <= DIV_RUN;
`endif
                end
`ifndef MULT_ITER_EN
                else if (start && is_mul) {hi, lo} <= sgn ? prod_s : prod_u;
`endif
                else if (start && code == MTHI_C) hi <= bus.src_a_i;
                else if (start && code == MTLO_C) lo <= bus.src_a_i;
            end else if (bus.flush_i) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                acc <= run_acc;
                sh  <= run_sh;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef MULT_ITER_EN
                    if (state == MUL_RUN) {hi, lo} <= (sa ^ sb) ? -{run_acc, run_sh} : {run_acc, run_sh};
                    else begin
                        lo <= (sa ^ sb) ? -run_sh : run_sh;
                        hi <= sa ? -run_acc : run_acc;
                    end
`else
                    lo <= (sa ^ sb) ? -run_sh : run_sh;
                    hi <= sa ? -run_acc : run_acc;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench for hilo_muldiv_unit (HI/LO results, stall length, abort)
module tb_hilo_muldiv_unit;
    localparam logic [4:0] MULT_C  = 5'b11000;
    localparam logic [4:0] MULTU_C = 5'b11001;
    localparam logic [4:0] DIV_C   = 5'b11010;
    localparam logic [4:0] DIVU_C  = 5'b11011;
    localparam logic [4:0] MTHI_C  = 5'b11100;
    localparam logic [4:0] MTLO_C  = 5'b11101;
`ifdef MULT_ITER_EN
    localparam int MUL_STALL = 33;
`else
    localparam int MUL_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    hilo_muldiv_if #(.WIDTH(32)) bus();
    hilo_muldiv_unit #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (c)
            DIV_C:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            DIVU_C:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MULT_C:  return 64'(sa * sb);
            MULTU_C: return {32'h0, a} * {32'h0, b};
            MTHI_C:  return {a, m_lo};
            MTLO_C:  return {m_hi, a};
            default: return {m_hi, m_lo};
        endcase
    endfunction

    task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic v, input int exp_stall, input logic [63:0] exp);
        int n;
        logic [63:0] e;
        exp_q.push_back(exp);
        {m_hi, m_lo} = exp;
        @(negedge clk);
        bus.valid_i = v;
        bus.alucontrol_i = c;
        bus.src_a_i = a;
        bus.src_b_i = b;
        #1;
        n = 0;
        while (bus.stall_o && n < 200) begin
            n++;
            @(negedge clk);
            #1;
            if (n == 1 && exp_stall > 1) check("busy_run", 64'(bus.busy_o), 64'd1);
        end
        check("stall_cycles", 64'(n), 64'(exp_stall));
        @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        e = exp_q.pop_front();
        check("hi", 64'(bus.hi_o), 64'(e[63:32]));
        check("lo", 64'(bus.lo_o), 64'(e[31:0]));
        check("busy_idle", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input int at, input logic use_rst);
        logic [63:0] e;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.alucontrol_i = DIVU_C;
        bus.src_a_i = a;
        bus.src_b_i = b;
        repeat (at) @(negedge clk);
        if (use_rst) rst = 1'b1;
        else bus.flush_i = 1'b1;
        #1;
        if (!use_rst) check("stall_on_flush", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        if (use_rst) {m_hi, m_lo} = '0;
        exp_q.push_back({m_hi, m_lo});
        e = exp_q.pop_front();
        check("abort_hi", 64'(bus.hi_o), 64'(e[63:32]));
        check("abort_lo", 64'(bus.lo_o), 64'(e[31:0]));
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_stall", 64'(bus.stall_o), 64'd0);
    endtask

    initial begin
        logic [4:0] ops[4] = '{DIV_C, DIVU_C, MULT_C, MULTU_C};
        bus.valid_i = 1'b0;
        bus.alucontrol_i = '0;
        bus.src_a_i = '0;
        bus.src_b_i = '0;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hi", 64'(bus.hi_o), 64'd0);
        check("rst_lo", 64'(bus.lo_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_stall", 64'(bus.stall_o), 64'd0);

        do_op(MTHI_C, 32'h11, 32'h0, 1'b1, 0, {32'h11, 32'h0});
        do_op(MTLO_C, 32'h22, 32'h0, 1'b1, 0, {32'h11, 32'h22});
        do_op(DIVU_C, 32'd100, 32'd7, 1'b1, 33, {32'd2, 32'd14});
        do_op(DIV_C, -32'sd7, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(DIV_C, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'h0, 32'h8000_0000});
        do_op(DIVU_C, 32'd5, 32'd0, 1'b1, 1, {32'd5, 32'hFFFF_FFFF});
        do_op(MULT_C, 32'hFFFF_FFFE, 32'd3, 1'b1, MUL_STALL, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(MULTU_C, 32'hFFFF_FFFE, 32'd3, 1'b1, MUL_STALL, {32'd2, 32'hFFFF_FFFA});
        do_op(DIV_C, 32'd7, -32'sd2, 1'b1, 33, model(DIV_C, 32'd7, -32'sd2));
        do_op(DIV_C, -32'sd7, -32'sd2, 1'b1, 33, model(DIV_C, -32'sd7, -32'sd2));
        do_op(DIVU_C, 32'd9, 32'd2, 1'b0, 0, {m_hi, m_lo});
        do_op(5'b00010, 32'hDEAD, 32'hBEEF, 1'b1, 0, {m_hi, m_lo});

        do_op(MTHI_C, 32'h11, 32'h0, 1'b1, 0, model(MTHI_C, 32'h11, 32'h0));
        do_op(MTLO_C, 32'h22, 32'h0, 1'b1, 0, model(MTLO_C, 32'h22, 32'h0));
        abort_op(32'd9, 32'd2, 10, 1'b0);
        abort_op(32'd9, 32'd2, 5, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [4:0] c;
            logic [31:0] a, b;
            c = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            do_op(c, a, b, 1'b1,
                  (c == DIV_C || c == DIVU_C) ? ((b == 0) ? 1 : 33) : MUL_STALL,
                  model(c, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
